uart_echo_fifo: RTL and testbench



---
 rtl/uart_echo_fifo.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_uart_echo_fifo.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
// UART receiver that validates each frame, queues good characters in a FIFO
// and retransmits them with the same frame format.
module uart_echo_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_serial,
  output logic                          tx_serial,
  output logic                          rx_valid,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          overflow,
  input  logic                          clear_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);
  localparam logic          ODD_PAR   = (PARITY_ODD != 0);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_DONE
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  // Two-flop synchroniser; idles high so reset does not look like a start bit
  logic sync1_q, rxs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      rxs_q   <= sync1_q;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t              rx_state_q, rx_state_d;
  logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
  logic [2:0]             rx_idx_q, rx_idx_d;
  logic                   rx_stop_idx_q, rx_stop_idx_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_perr_q, rx_perr_d;
  logic                   rx_ferr_q, rx_ferr_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_frame_err_q, rx_frame_err_d;
  logic                   rx_parity_err_q, rx_parity_err_d;
  logic                   rx_push;

  always_comb begin
    rx_state_d      = rx_state_q;
    rx_cnt_d        = rx_cnt_q;
    rx_idx_d        = rx_idx_q;
    rx_stop_idx_d   = rx_stop_idx_q;
    rx_shift_d      = rx_shift_q;
    rx_perr_d       = rx_perr_q;
    rx_ferr_d       = rx_ferr_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = 1'b0;
    rx_frame_err_d  = 1'b0;
    rx_parity_err_d = 1'b0;
    rx_push         = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rxs_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Re-check the start bit at its centre; later samples land mid-bit
        if (rx_cnt_q == HALF_BIT) begin
          rx_cnt_d      = '0;
          rx_idx_d      = '0;
          rx_stop_idx_d = 1'b0;
          rx_perr_d     = 1'b0;
          rx_ferr_d     = 1'b0;
          rx_state_d    = rxs_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxs_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == DATA_LAST) rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
          else                       rx_idx_d   = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_perr_d  = ((^rx_shift_q) ^ rxs_q) != ODD_PAR;
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (!rxs_q) rx_ferr_d = 1'b1;
          if (rx_stop_idx_q == STOP_LAST) rx_state_d    = RX_DONE;
          else                            rx_stop_idx_d = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DONE: begin
        rx_state_d = RX_IDLE;
        if (rx_ferr_q) begin
          rx_frame_err_d = 1'b1;
        end else if (rx_perr_q) begin
          rx_parity_err_d = 1'b1;
        end else begin
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift_q;
          rx_push    = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q      <= RX_IDLE;
      rx_cnt_q        <= '0;
      rx_idx_q        <= '0;
      rx_stop_idx_q   <= 1'b0;
      rx_shift_q      <= '0;
      rx_perr_q       <= 1'b0;
      rx_ferr_q       <= 1'b0;
      rx_valid_q      <= 1'b0;
      rx_data_q       <= '0;
      rx_frame_err_q  <= 1'b0;
      rx_parity_err_q <= 1'b0;
    end else begin
      rx_state_q      <= rx_state_d;
      rx_cnt_q        <= rx_cnt_d;
      rx_idx_q        <= rx_idx_d;
      rx_stop_idx_q   <= rx_stop_idx_d;
      rx_shift_q      <= rx_shift_d;
      rx_perr_q       <= rx_perr_d;
      rx_ferr_q       <= rx_ferr_d;
      rx_valid_q      <= rx_valid_d;
      rx_data_q       <= rx_data_d;
      rx_frame_err_q  <= rx_frame_err_d;
      rx_parity_err_q <= rx_parity_err_d;
    end
  end

  // ---------------- FIFO ----------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 fifo_full, push_ok, tx_pop;

  assign fifo_full = (count_q == FULL_CNT);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push_ok   = rx_push && (!fifo_full || tx_pop);

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = tx_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case ({push_ok, tx_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (rx_push && fifo_full && !tx_pop) overflow_d = 1'b1;
    else if (clear_err)                  overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  // ---------------- transmitter ----------------
  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_idx_q, tx_idx_d;
  logic                 tx_stop_idx_q, tx_stop_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_serial_q, tx_serial_d;
  logic                 tx_busy_q, tx_busy_d;

  // tx_serial_d carries the level of the state being entered so the pin is registered
  always_comb begin
    tx_state_d    = tx_state_q;
    tx_cnt_d      = tx_cnt_q;
    tx_idx_d      = tx_idx_q;
    tx_stop_idx_d = tx_stop_idx_q;
    tx_shift_d    = tx_shift_q;
    tx_par_d      = tx_par_q;
    tx_serial_d   = tx_serial_q;
    tx_pop        = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_serial_d   = 1'b1;
        tx_cnt_d      = '0;
        tx_stop_idx_d = 1'b0;
        if (count_q != '0) begin
          tx_pop      = 1'b1;
          tx_shift_d  = mem_q[rd_ptr_q];
          tx_par_d    = (^mem_q[rd_ptr_q]) ^ ODD_PAR;
          tx_state_d  = TX_START;
          tx_serial_d = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d    = '0;
          tx_idx_d    = '0;
          tx_state_d  = TX_DATA;
          tx_serial_d = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == DATA_LAST) begin
            if (HAS_PAR) begin
              tx_state_d  = TX_PARITY;
              tx_serial_d = tx_par_q;
            end else begin
              tx_state_d  = TX_STOP;
              tx_serial_d = 1'b1;
            end
          end else begin
            tx_idx_d    = tx_idx_q + 3'd1;
            tx_shift_d  = tx_shift_q >> 1;
            tx_serial_d = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_PARITY: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d    = '0;
          tx_state_d  = TX_STOP;
          tx_serial_d = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        tx_serial_d = 1'b1;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_stop_idx_q == STOP_LAST) tx_state_d    = TX_IDLE;
          else                            tx_stop_idx_d = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: begin
        tx_state_d  = TX_IDLE;
        tx_serial_d = 1'b1;
      end
    endcase
    tx_busy_d = (tx_state_d != TX_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q    <= TX_IDLE;
      tx_cnt_q      <= '0;
      tx_idx_q      <= '0;
      tx_stop_idx_q <= 1'b0;
      tx_shift_q    <= '0;
      tx_par_q      <= 1'b0;
      tx_serial_q   <= 1'b1;
      tx_busy_q     <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_idx_q      <= tx_idx_d;
      tx_stop_idx_q <= tx_stop_idx_d;
      tx_shift_q    <= tx_shift_d;
      tx_par_q      <= tx_par_d;
      tx_serial_q   <= tx_serial_d;
      tx_busy_q     <= tx_busy_d;
    end
  end

  assign tx_serial     = tx_serial_q;
  assign tx_busy       = tx_busy_q;
  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_frame_err  = rx_frame_err_q;
  assign rx_parity_err = rx_parity_err_q;
  assign overflow      = overflow_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: an 8E2 instance for framing/parity/echo/reset checks
// and a fast 8N1 instance whose transmitter falls behind to exercise overflow.
module tb_uart_echo_fifo;

  localparam int CPB_M = 16;
  localparam int CPB_O = 4;

  logic clk, rst;
  logic rx_m, tx_m, rxv_m, fe_m, pe_m, ovf_m, clr_m, busy_m;
  logic [7:0] rxd_m;
  logic [2:0] cnt_m;
  logic rx_o, tx_o, rxv_o, fe_o, pe_o, ovf_o, clr_o, busy_o;
  logic [7:0] rxd_o;
  logic [1:0] cnt_o;

  uart_echo_fifo #(.CLKS_PER_BIT(CPB_M), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_main (
    .clk(clk), .rst(rst), .rx_serial(rx_m), .tx_serial(tx_m), .rx_valid(rxv_m),
    .rx_data(rxd_m), .rx_frame_err(fe_m), .rx_parity_err(pe_m), .overflow(ovf_m),
    .clear_err(clr_m), .fifo_count(cnt_m), .tx_busy(busy_m));

  uart_echo_fifo #(.CLKS_PER_BIT(CPB_O), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(2)) u_ovf (
    .clk(clk), .rst(rst), .rx_serial(rx_o), .tx_serial(tx_o), .rx_valid(rxv_o),
    .rx_data(rxd_o), .rx_frame_err(fe_o), .rx_parity_err(pe_o), .overflow(ovf_o),
    .clear_err(clr_o), .fifo_count(cnt_o), .tx_busy(busy_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: characters expected back on tx_m, in order
  logic [7:0] exp_q[$];
  logic [7:0] o_got[$];
  int nv = 0, nfe = 0, npe = 0;
  int max_m = 0, max_o = 0;
  bit o_seen = 0, o_fell = 0;

  // RX event counters and occupancy tracking
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (rxv_m) nv++;
      if (fe_m)  nfe++;
      if (pe_m)  npe++;
      if (int'(cnt_m) > max_m) max_m = int'(cnt_m);
      if (int'(cnt_o) > max_o) max_o = int'(cnt_o);
      if (ovf_o) o_seen = 1;
      else if (o_seen && !clr_o) o_fell = 1;
    end
  end

  // Decoder for the 8E2 echo: every bit must hold for exactly CPB_M cycles
  bit m_act = 0;
  int m_cnt = 0;
  initial begin
    logic [11:0] bits;
    logic [7:0]  d;
    bit          unstable;
    int          k;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_act = 0;
      end else begin
        if (!m_act && tx_m == 1'b0) begin
          m_act = 1; m_cnt = 0; unstable = 0; bits = '0;
        end
        if (m_act) begin
          k = m_cnt / CPB_M;
          if (m_cnt % CPB_M == 0) bits[k] = tx_m;
          else if (tx_m !== bits[k]) unstable = 1;
          if (m_cnt == 12 * CPB_M - 1) begin
            m_act = 0;
            d = bits[8:1];
            check_eq("tx_bit_width", 32'(unstable), 0);
            check_eq("tx_parity", 32'(bits[9]), 32'(^d));
            check_eq("tx_stop", 32'(bits[11:10]), 2'b11);
            if (exp_q.size() == 0) check_eq("tx_unexpected_char", 32'(d), 32'h100);
            else check_eq("tx_data", 32'(d), 32'(exp_q.pop_front()));
          end
          m_cnt++;
        end
      end
    end
  end

  // Decoder for the 8N1 overflow instance
  bit o_act = 0;
  initial begin
    logic [9:0] bits;
    bit         unstable;
    int         cnt, k;
    forever begin
      @(negedge clk);
      if (rst) begin
        o_act = 0;
      end else begin
        if (!o_act && tx_o == 1'b0) begin
          o_act = 1; cnt = 0; unstable = 0; bits = '0;
        end
        if (o_act) begin
          k = cnt / CPB_O;
          if (cnt % CPB_O == 0) bits[k] = tx_o;
          else if (tx_o !== bits[k]) unstable = 1;
          if (cnt == 10 * CPB_O - 1) begin
            o_act = 0;
            check_eq("ovf_tx_frame", {unstable, bits[9]}, 2'b01);
            o_got.push_back(bits[8:1]);
          end
          cnt++;
        end
      end
    end
  end

  task automatic send_main(input logic [7:0] d, input bit bad_par, input logic [1:0] stop_val,
                           input int gap);
    logic [11:0] f;
    f = {stop_val, (^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 12; i++) begin
      rx_m = f[i];
      repeat (CPB_M) @(negedge clk);
    end
    rx_m = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_ovf(input logic [7:0] d);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_o = f[i];
      repeat (CPB_O) @(negedge clk);
    end
  endtask

  // One character into the 8E2 instance, checked against the framing rules
  task automatic xact(input logic [7:0] d, input bit bad_par, input logic [1:0] stop_val,
                      input int gap);
    int  v0, f0, p0;
    bit  e_fe, e_pe, good;
    v0 = nv; f0 = nfe; p0 = npe;
    e_fe = (stop_val != 2'b11);
    e_pe = !e_fe && bad_par;
    good = !e_fe && !e_pe;
    if (good) exp_q.push_back(d);
    send_main(d, bad_par, stop_val, gap);
    check_eq("rx_valid_pulses", 32'(nv - v0), 32'(good));
    check_eq("rx_frame_err_pulses", 32'(nfe - f0), 32'(e_fe));
    check_eq("rx_parity_err_pulses", 32'(npe - p0), 32'(e_pe));
    if (good) check_eq("rx_data", 32'(rxd_m), 32'(d));
    $display("[TB] rx 0x%02h bad_par=%0d stop=%b -> valid=%0d frame_err=%0d parity_err=%0d",
             d, bad_par, stop_val, nv - v0, nfe - f0, npe - p0);
  endtask

  task automatic drain_main();
    int t;
    t = 0;
    while (t < 3000 && (exp_q.size() != 0 || busy_m || m_act)) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_main_timeout", 32'(t < 3000), 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, viol;
    logic [7:0] d;
    int r;
    logic [1:0] sv;
    rst = 1'b1; rx_m = 1'b1; rx_o = 1'b1; clr_m = 1'b0; clr_o = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_tx_serial", 32'(tx_m), 1);
    check_eq("reset_flags", {rxv_m, fe_m, pe_m, ovf_m, busy_m}, 0);
    check_eq("reset_rx_data", 32'(rxd_m), 0);
    check_eq("reset_fifo_count", 32'(cnt_m), 0);

    // Basic echo; transmitter should already be busy when the frame ends
    xact(8'hA5, 0, 2'b11, 20);
    check_eq("echo_busy", 32'(busy_m), 1);
    check_eq("echo_popped", 32'(cnt_m), 0);
    drain_main();

    // Parity error: nothing queued, line stays idle
    xact(8'h03, 1, 2'b11, 20);
    check_eq("perr_fifo_count", 32'(cnt_m), 0);
    check_eq("perr_tx_idle", {tx_m, busy_m}, 2'b10);
    xact(8'h03, 0, 2'b11, 20);
    drain_main();

    // Framing errors, including frame error taking priority over parity
    xact(8'h55, 0, 2'b10, 20);
    check_eq("ferr_tx_idle", {tx_m, busy_m, cnt_m}, 5'b10000);
    xact(8'h55, 1, 2'b00, 20);
    xact(8'hC3, 0, 2'b01, 20);
    xact(8'h0F, 0, 2'b11, 20);
    drain_main();

    // Start-bit glitch of 5 clocks
    t = nv + nfe + npe;
    rx_m = 1'b0;
    repeat (5) @(negedge clk);
    rx_m = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("glitch_no_flags", 32'(nv + nfe + npe - t), 0);
    check_eq("glitch_tx_idle", {tx_m, busy_m, cnt_m}, 5'b10000);
    xact(8'h5A, 0, 2'b11, 20);
    drain_main();

    // Randomised traffic with occasional parity/framing faults
    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom_range(0, 255));
      r  = int'($urandom_range(0, 9));
      sv = (r == 2) ? 2'b10 : (r == 3) ? 2'b01 : 2'b11;
      xact(d, r < 2, sv, int'($urandom_range(20, 60)));
    end
    drain_main();
    check_eq("main_no_overflow", 32'(ovf_m), 0);
    check_eq("main_max_count", 32'(max_m <= 4), 1);

    // Reset during data bit 3 of an echo
    xact(8'h3C, 0, 2'b11, 20);
    t = 0;
    while (t < 1000 && !(m_act && m_cnt >= 4 * CPB_M + 6)) begin
      @(negedge clk);
      t++;
    end
    check_eq("reset_wait_bit3", 32'(m_act && m_cnt >= 4 * CPB_M + 6), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_tx_serial", 32'(tx_m), 1);
    check_eq("midrst_fifo_count", 32'(cnt_m), 0);
    check_eq("midrst_busy", 32'(busy_m), 0);
    check_eq("midrst_rx_data", 32'(rxd_m), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    xact(8'h7E, 0, 2'b11, 20);
    drain_main();

    // Overflow: back-to-back 8N1 frames arrive one clock faster than they leave
    for (int i = 0; i < 200; i++) begin
      if (i == 20) check_eq("ovf_not_yet", 32'(ovf_o), 0);
      send_ovf(8'(i));
    end
    t = 0;
    while (t < 1000 && (busy_o || cnt_o != 0 || o_act)) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_ovf_timeout", 32'(t < 1000), 1);
    check_eq("ovf_set", 32'(ovf_o), 1);
    check_eq("ovf_sticky", 32'(o_fell), 0);
    check_eq("ovf_max_count", 32'(max_o <= 2), 1);
    check_eq("ovf_rx_errors", {fe_o, pe_o}, 0);
    check_eq("ovf_dropped_some", 32'(o_got.size() < 200 && o_got.size() > 150), 1);
    for (int i = 0; i < 10; i++) check_eq("ovf_prefix", 32'(o_got[i]), i);
    viol = 0;
    for (int i = 1; i < o_got.size(); i++) if (o_got[i] <= o_got[i-1]) viol++;
    check_eq("ovf_order_no_dup", 32'(viol), 0);
    $display("[TB] overflow run: 200 sent, %0d echoed", o_got.size());
    clr_o = 1'b1;
    @(negedge clk);
    clr_o = 1'b0;
    check_eq("ovf_cleared", 32'(ovf_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
